// File: rtl/beta_alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops plus an iterative shifter
// that moves ShiftStep bits per cycle for long shift amounts.
module beta_alu_mc #(
   parameter int DataWidth = 32,
   parameter int ShiftStep = 4
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 alu_valid_i,
   output logic                 alu_ready_o,
   input  logic [DataWidth-1:0] alu_operand_a_i,
   input  logic [DataWidth-1:0] alu_operand_b_i,
   input  logic [3:0]           alu_op_i,
   input  logic                 alu_flush_i,
   output logic                 alu_op_end_o,
   output logic [DataWidth-1:0] alu_result_o,
   output logic [2:0]           alu_stat_o
);

   // state | meaning
   // IDLE  | ready; single-cycle ops complete here, long shifts start here
   // SHIFT | iterative shift in progress, ready=0

   localparam int SW = $clog2(DataWidth);
   localparam int CW = SW + 1;
   localparam logic [CW-1:0] StepC = CW'(ShiftStep);

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_SLTU = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;

   typedef enum logic {IDLE, SHIFT} state_e;

   typedef struct packed {
      logic zero;
      logic overflow;
      logic negative;
   } exe_alu_status_t;

   state_e               state_q, state_d;
   logic [DataWidth-1:0] acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           shop_q, shop_d;
   exe_alu_status_t      spend_q, spend_d;
   logic [DataWidth-1:0] result_q, result_d;
   exe_alu_status_t      stat_q, stat_d;
   logic                 op_end_q, op_end_d;

   logic [DataWidth-1:0] a, b, sum, diff, single_res;
   logic [CW-1:0]        shamt;
   logic                 lt_s, lt_u, is_shift, multi;
   exe_alu_status_t      stat_now;

   function automatic logic [DataWidth-1:0] shift_fn(input logic [3:0]           op,
                                                     input logic [DataWidth-1:0] val,
                                                     input logic [CW-1:0]        amt);
      case (op)
         OP_SLL:  shift_fn = val << amt;
         OP_SRL:  shift_fn = val >> amt;
         default: shift_fn = $signed(val) >>> amt;
      endcase
   endfunction

   always_comb begin
      a        = alu_operand_a_i;
      b        = alu_operand_b_i;
      sum      = a + b;
      diff     = a + ~b + 1'b1;
      lt_s     = $signed(a) < $signed(b);
      lt_u     = a < b;
      shamt    = {1'b0, b[SW-1:0]};
      is_shift = (alu_op_i == OP_SLL) || (alu_op_i == OP_SRL) || (alu_op_i == OP_SRA);
      multi    = is_shift && (shamt > StepC);

      stat_now.zero     = (diff == '0);
      stat_now.negative = ((alu_op_i == OP_SLTU) ? lt_u : lt_s) && !stat_now.zero;
      case (alu_op_i)
         OP_ADD:  stat_now.overflow = (a[DataWidth-1] == b[DataWidth-1]) &&
                                      (sum[DataWidth-1] != a[DataWidth-1]);
         OP_SUB:  stat_now.overflow = (a[DataWidth-1] != b[DataWidth-1]) &&
                                      (diff[DataWidth-1] != a[DataWidth-1]);
         default: stat_now.overflow = 1'b0;
      endcase

      case (alu_op_i)
         OP_ADD:                 single_res = sum;
         OP_SUB:                 single_res = diff;
         OP_AND:                 single_res = a & b;
         OP_OR:                  single_res = a | b;
         OP_XOR:                 single_res = a ^ b;
         OP_SLT:                 single_res = DataWidth'(lt_s);
         OP_SLTU:                single_res = DataWidth'(lt_u);
         OP_SLL, OP_SRL, OP_SRA: single_res = shift_fn(alu_op_i, a, shamt);
         default:                single_res = a;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      shop_d   = shop_q;
      spend_d  = spend_q;
      result_d = result_q;
      stat_d   = stat_q;
      op_end_d = 1'b0;

      if (alu_flush_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (alu_valid_i) begin
                  if (multi) begin
                     // First step happens on the accept edge so completion lands at t+N.
                     state_d = SHIFT;
                     acc_d   = shift_fn(alu_op_i, a, StepC);
                     cnt_d   = shamt - StepC;
                     shop_d  = alu_op_i;
                     spend_d = stat_now;
                  end else begin
                     result_d = single_res;
                     stat_d   = stat_now;
                     op_end_d = 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (cnt_q <= StepC) begin
                  result_d = shift_fn(shop_q, acc_q, cnt_q);
                  stat_d   = spend_q;
                  op_end_d = 1'b1;
                  cnt_d    = '0;
                  state_d  = IDLE;
               end else begin
                  acc_d = shift_fn(shop_q, acc_q, StepC);
                  cnt_d = cnt_q - StepC;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         shop_q   <= '0;
         spend_q  <= '0;
         result_q <= '0;
         stat_q   <= '0;
         op_end_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         shop_q   <= shop_d;
         spend_q  <= spend_d;
         result_q <= result_d;
         stat_q   <= stat_d;
         op_end_q <= op_end_d;
      end
   end

   assign alu_ready_o  = (state_q == IDLE);
   assign alu_op_end_o = op_end_q;
   assign alu_result_o = result_q;
   assign alu_stat_o   = stat_q;

endmodule
